// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, PC redirect and wrong-path squash.
// A small IDLE/SHADOW machine counts the younger capture slots to bubble after a taken branch.
module ex_mem_stage #(
    parameter int unsigned SHADOW_DEPTH = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        ValidIn,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic [31:0] WriteDataIn,
    input  logic [4:0]  RegDstIn,
    input  logic        RegWriteIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        MemToRegIn,
    input  logic [2:0]  BranchTypeIn,
    input  logic [31:0] BranchTargetIn,
    output logic        ValidOut,
    output logic [31:0] ALUResultOut,
    output logic [31:0] WriteDataOut,
    output logic [4:0]  RegDstOut,
    output logic        RegWriteOut,
    output logic        MemReadOut,
    output logic        MemWriteOut,
    output logic        MemToRegOut,
    output logic        Redirect,
    output logic [31:0] BranchTargetOut,
    output logic        FwdValid,
    output logic [4:0]  FwdReg,
    output logic [31:0] FwdData
);
    localparam logic [1:0] DEPTH = 2'(SHADOW_DEPTH);

    typedef enum logic {IDLE, SHADOW} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] wd_q, wd_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, mtr_q, mtr_d;
    logic        redirect_q, redirect_d;
    logic [31:0] target_q, target_d;

    logic squash, bubble, cond, take;

    always_comb begin
        unique case (BranchTypeIn)
            3'd1:    cond = Zero;
            3'd2:    cond = ~Zero;
            3'd3:    cond = ALUResult[31];
            3'd4:    cond = ~ALUResult[31];
            3'd5:    cond = ~Zero & ~ALUResult[31];
            3'd6:    cond = Zero | ALUResult[31];
            3'd7:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Squashed slots never evaluate the branch, so a second taken branch cannot start inside the shadow.
    assign squash = (state_q == SHADOW);
    assign bubble = Flush | squash;
    assign take   = ValidIn & ~bubble & cond;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        alu_d      = alu_q;
        wd_d       = wd_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        mtr_d      = mtr_q;
        target_d   = target_q;
        redirect_d = 1'b0;
        if (!Stall) begin
            valid_d    = ValidIn & ~bubble;
            alu_d      = ALUResult;
            wd_d       = WriteDataIn;
            rd_d       = RegDstIn;
            rw_d       = RegWriteIn & valid_d;
            mr_d       = MemReadIn  & valid_d;
            mw_d       = MemWriteIn & valid_d;
            mtr_d      = MemToRegIn & valid_d;
            redirect_d = take;
            if (take) target_d = BranchTargetIn;
            unique case (state_q)
                IDLE: if (take) begin
                    state_d = SHADOW;
                    cnt_d   = DEPTH;
                end
                SHADOW: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            valid_q    <= 1'b0;
            alu_q      <= '0;
            wd_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            mr_q       <= 1'b0;
            mw_q       <= 1'b0;
            mtr_q      <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            wd_q       <= wd_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            mr_q       <= mr_d;
            mw_q       <= mw_d;
            mtr_q      <= mtr_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign ValidOut        = valid_q;
    assign ALUResultOut    = alu_q;
    assign WriteDataOut    = wd_q;
    assign RegDstOut       = rd_q;
    assign RegWriteOut     = rw_q  & valid_q;
    assign MemReadOut      = mr_q  & valid_q;
    assign MemWriteOut     = mw_q  & valid_q;
    assign MemToRegOut     = mtr_q & valid_q;
    assign Redirect        = redirect_q;
    assign BranchTargetOut = target_q;
    assign FwdValid        = valid_q & rw_q & (rd_q != 5'd0);
    assign FwdReg          = rd_q;
    assign FwdData         = alu_q;
endmodule
